exec_sequencer: RTL and testbench
=================================

Name: exec_sequencer

Overview:
- Multicycle sequencer for the accumulator core.
- Owns the program counter and steps each instruction through FETCH, DECODE, EXEC, optional MEM and WB.
- Issues one-hot per-phase enables to the instruction register, register file and data memory, using the control decoder's Branch/MemRead/MemWrite outputs.
- Counts executed cycles and reports program completion to the top-level test harness.

Parameters:
- PC_W, 10, program counter width; PC wraps modulo 2^PC_W.
- CNT_W, 16, cycle counter width; the counter saturates at its maximum.

Ports:
- Clk  input  1  core clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-high; clears all state immediately.
- Start  input  1  level; sampled only in IDLE or HALT.
- Halt  input  1  decoded halt opcode (kHALT); valid in DECODE.
- Branch  input  1  from control decoder; valid in EXEC and WB.
- BrTaken  input  1  ALU compare result for BEQ/BNE; valid in WB.
- MemRead  input  1  from control decoder.
- MemWrite  input  1  from control decoder.
- Target  input  PC_W  absolute branch target from the branch LUT.
- MemAck  input  1  data memory completion; may arrive any number of cycles after MemReq.
- PC  output  PC_W  current instruction address.
- IRLoad  output  1  instruction register capture enable.
- MemReq  output  1  data memory request.
- MemWe  output  1  memory write qualifier; valid while MemReq=1.
- RegWrite  output  1  register/accumulator write enable.
- Done  output  1  program finished.
- CycleCount  output  CNT_W  cycles spent executing.

Behaviour:
- Reset values: state=IDLE, PC=0, CycleCount=0. All outputs are 0.
- Reset asserted in any state, including MEM with a request outstanding, aborts immediately. A late MemAck arriving after reset is ignored.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. The state register is 3 bits, encoded in the package.
- IDLE:
  - Start=1 -> PC<=0, CycleCount<=0, go to FETCH.
  - Otherwise stay in IDLE.
- FETCH:
  - IRLoad=1 for exactly one cycle; the instruction ROM is combinational on PC.
  - Next state: DECODE.
- DECODE:
  - Halt=1 -> HALT; PC is not advanced.
  - Otherwise -> EXEC.
- EXEC:
  - One cycle.
  - MemRead|MemWrite -> MEM.
  - Otherwise -> WB.
- MEM:
  - MemReq=1 held continuously until the cycle in which MemAck=1.
  - MemWe=MemWrite. If both MemRead and MemWrite are asserted, the operation is a write (MemWe=1).
  - MemAck=1 -> WB in the next cycle.
  - MemAck outside MEM is ignored.
- WB:
  - RegWrite = ~(MemWrite | Branch).
  - Branch & BrTaken -> PC<=Target; otherwise PC<=PC+1, wrapping from 2^PC_W-1 to 0.
  - Next state: FETCH.
- HALT:
  - Done=1 and PC is frozen.
  - Start=1 -> PC<=0, CycleCount<=0, Done deasserts, go to FETCH.
- Start is ignored in FETCH, DECODE, EXEC, MEM and WB.
- CycleCount increments by 1 in every cycle where state is not IDLE or HALT. It saturates at 2^CNT_W-1 and never wraps.
- All outputs are registered state or decoded from state only; there are no combinational paths from inputs to outputs.
- Latency per instruction:
  - Non-memory instruction: 4 cycles.
  - Memory instruction: 4 cycles + the MEM cycles, minimum 5 when MemAck arrives on the first MEM cycle.

Decomposition:
- Shared definitions package gains:
  - the state enum type seq_state_t;
  - the constant kHALT = 4'b1111;
  - the PC_W default constant.
- One natural sub-module: cycle_counter, the saturating counter with synchronous clear and enable.
- The FSM and the PC register stay in exec_sequencer.

Test Plan:
- Reset then Start=1 with a non-memory, non-branch instruction.
  - Required: IRLoad at cycle 1; RegWrite at cycle 4; PC=1 at cycle 5; CycleCount=4 at that point.
- Load instruction (MemRead=1) with MemAck delayed 3 cycles.
  - Required: MemReq high for exactly 3 cycles; WB follows; 7 cycles total; RegWrite=1.
- Store (MemWrite=1).
  - Required: MemWe=1 throughout MEM; RegWrite=0 in WB.
- Branch=1 with BrTaken=1 and Target=10'h2A.
  - Required: PC=2A after WB.
- Branch=1 with BrTaken=0 and PC=3FF.
  - Required: PC wraps to 0; RegWrite=0.
- Halt asserted in DECODE at PC=5.
  - Required: Done=1 and PC stays 5.
  - Then Start=1: PC=0 and Done=0 on the next cycle.
- Reset pulsed mid-MEM, followed by MemAck.
  - Required: IDLE with all outputs 0; MemAck has no effect.

Source files
------------

// File: rtl/exec_sequencer_pkg.sv
// Shared definitions for the multicycle execution sequencer:
// state encoding, halt opcode and default widths.
package exec_sequencer_pkg;

    localparam int PC_W_DEF  = 10;
    localparam int CNT_W_DEF = 16;

    localparam logic [3:0] kHALT = 4'b1111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } seq_state_t;

    // True while an instruction is in flight; these are the cycles that get counted.
    function automatic logic is_running(input seq_state_t s);
        return (s != S_IDLE) && (s != S_HALT);
    endfunction

endpackage

// File: rtl/exec_sequencer_cycle_counter.sv
// Saturating cycle counter with synchronous clear (priority) and count enable.
module cycle_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/exec_sequencer.sv
// Multicycle sequencer: owns the PC, steps FETCH/DECODE/EXEC/[MEM]/WB and
// drives registered per-phase enables; seq_state exposes the FSM state.
module exec_sequencer
    import exec_sequencer_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Halt,
    input  logic             Branch,
    input  logic             BrTaken,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic [PC_W-1:0]  Target,
    input  logic             MemAck,
    output logic [PC_W-1:0]  PC,
    output logic             IRLoad,
    output logic             MemReq,
    output logic             MemWe,
    output logic             RegWrite,
    output logic             Done,
    output logic [CNT_W-1:0] CycleCount,
    output logic [2:0]       seq_state
);

    seq_state_t state;
    logic       wb_write;
    logic       launch;

    assign seq_state = state;

    // Start is honoured only from IDLE or HALT; it also restarts the cycle count.
    assign launch = Start && ((state == S_IDLE) || (state == S_HALT));

    cycle_counter #(
        .W(CNT_W)
    ) u_cycle_counter (
        .clk    (Clk),
        .rst    (Reset),
        .clear  (launch),
        .enable (is_running(state)),
        .count  (CycleCount)
    );

    // Every output is a register set on the transition into the phase that owns it,
    // so no input reaches an output combinationally.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= S_IDLE;
            PC       <= '0;
            IRLoad   <= 1'b0;
            MemReq   <= 1'b0;
            MemWe    <= 1'b0;
            RegWrite <= 1'b0;
            Done     <= 1'b0;
            wb_write <= 1'b0;
        end else begin
            IRLoad   <= 1'b0;
            RegWrite <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        PC     <= '0;
                        IRLoad <= 1'b1;
                        state  <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    if (Halt) begin
                        Done  <= 1'b1;
                        state <= S_HALT;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // Branch is only guaranteed valid here and in WB, so the
                    // write-back enable is decided now and carried through MEM.
                    wb_write <= ~(MemWrite | Branch);
                    if (MemRead | MemWrite) begin
                        MemReq <= 1'b1;
                        MemWe  <= MemWrite;
                        state  <= S_MEM;
                    end else begin
                        RegWrite <= ~(MemWrite | Branch);
                        state    <= S_WB;
                    end
                end
                S_MEM: begin
                    if (MemAck) begin
                        MemReq   <= 1'b0;
                        MemWe    <= 1'b0;
                        RegWrite <= wb_write;
                        state    <= S_WB;
                    end
                end
                S_WB: begin
                    if (Branch && BrTaken) begin
                        PC <= Target;
                    end else begin
                        PC <= PC + 1'b1;
                    end
                    IRLoad <= 1'b1;
                    state  <= S_FETCH;
                end
                S_HALT: begin
                    if (Start) begin
                        PC     <= '0;
                        Done   <= 1'b0;
                        IRLoad <= 1'b1;
                        state  <= S_FETCH;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer: instruction-level model predicts every cycle's
// outputs; directed cases pin the model with literal values.
module tb_exec_sequencer;

    localparam int PW = 10;
    localparam int CW = 8;
    localparam int VW = PW + 5 + CW;
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic          Clk = 1'b0;
    logic          Reset;
    logic          Start;
    logic          Halt;
    logic          Branch;
    logic          BrTaken;
    logic          MemRead;
    logic          MemWrite;
    logic [PW-1:0] Target;
    logic          MemAck;
    logic [PW-1:0] PC;
    logic          IRLoad;
    logic          MemReq;
    logic          MemWe;
    logic          RegWrite;
    logic          Done;
    logic [CW-1:0] CycleCount;
    logic [2:0]    seq_state;

    int checks = 0;
    int errors = 0;
    int mem_req_cycles = 0;

    logic [VW-1:0] exp_q[$];
    logic [PW-1:0] m_pc;
    logic [CW-1:0] m_cnt;
    logic          m_done;

    exec_sequencer #(
        .PC_W  (PW),
        .CNT_W (CW)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .Halt       (Halt),
        .Branch     (Branch),
        .BrTaken    (BrTaken),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Target     (Target),
        .MemAck     (MemAck),
        .PC         (PC),
        .IRLoad     (IRLoad),
        .MemReq     (MemReq),
        .MemWe      (MemWe),
        .RegWrite   (RegWrite),
        .Done       (Done),
        .CycleCount (CycleCount),
        .seq_state  (seq_state)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle: predict outputs for the current phase, compare mid-cycle,
    // then advance the model across the rising edge.
    task automatic cycle(input logic irl, input logic req, input logic we, input logic rw,
                         input logic busy, input logic restart);
        logic [VW-1:0] e;
        logic [VW-1:0] a;
        exp_q.push_back({m_pc, irl, req, we, rw, m_done, m_cnt});
        @(negedge Clk);
        a = {PC, IRLoad, MemReq, MemWe, RegWrite, Done, CycleCount};
        e = exp_q.pop_front();
        mem_req_cycles += int'(MemReq);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL outputs @%0t: got pc=%h irl/req/we/rw/done=%b cnt=%0d expected pc=%h irl/req/we/rw/done=%b cnt=%0d",
                     $time, a[VW-1:CW+5], a[CW+4:CW], a[CW-1:0],
                     e[VW-1:CW+5], e[CW+4:CW], e[CW-1:0]);
        end
        @(posedge Clk);
        #1;
        if (restart) begin
            m_pc   = '0;
            m_cnt  = '0;
            m_done = 1'b0;
        end else if (busy && (m_cnt != CNT_MAX)) begin
            m_cnt = m_cnt + 1'b1;
        end
    endtask

    task automatic noise();
        Start  = 1'($urandom_range(0, 1));
        MemAck = 1'($urandom_range(0, 1));
    endtask

    task automatic quiet_cycle();
        Start  = 1'b0;
        MemAck = 1'($urandom_range(0, 1));
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic restart_cycle();
        Start  = 1'b1;
        MemAck = 1'($urandom_range(0, 1));
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        Start = 1'b0;
    endtask

    task automatic run_instr(input logic halt, input logic br, input logic tk, input logic rd,
                             input logic wr, input logic [PW-1:0] tgt, input int dly);
        Halt = halt; Branch = br; BrTaken = tk; MemRead = rd; MemWrite = wr; Target = tgt;
        noise(); cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        noise(); cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        if (halt) begin
            m_done = 1'b1;
            return;
        end
        noise(); cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        if (rd || wr) begin
            for (int i = 1; i <= dly; i++) begin
                Start  = 1'($urandom_range(0, 1));
                MemAck = (i == dly);
                cycle(1'b0, 1'b1, wr, 1'b0, 1'b1, 1'b0);
            end
        end
        noise(); cycle(1'b0, 1'b0, 1'b0, !(wr || br), 1'b1, 1'b0);
        if (br && tk) m_pc = tgt;
        else          m_pc = PW'((int'(m_pc) + 1) % (1 << PW));
    endtask

    task automatic rand_instr(input logic allow_halt);
        logic h;
        h = allow_halt && ($urandom_range(0, 11) == 0);
        run_instr(h, ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                  PW'($urandom), $urandom_range(1, 4));
        if (h) begin
            repeat ($urandom_range(1, 3)) quiet_cycle();
            restart_cycle();
        end
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; Halt = 1'b0; Branch = 1'b0; BrTaken = 1'b0;
        MemRead = 1'b0; MemWrite = 1'b0; Target = '0; MemAck = 1'b0;
        m_pc = '0; m_cnt = '0; m_done = 1'b0;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        chk("reset_pc", 32'(PC), 0);
        chk("reset_flags", 32'({IRLoad, MemReq, MemWe, RegWrite, Done}), 0);
        chk("reset_cnt", 32'(CycleCount), 0);
        repeat (2) quiet_cycle();
        restart_cycle();

        run_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1);
        chk("alu_pc", 32'(PC), 1);
        chk("alu_cnt", 32'(CycleCount), 4);

        mem_req_cycles = 0;
        run_instr(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, 3);
        chk("load_req_cycles", 32'(mem_req_cycles), 3);
        chk("load_cnt", 32'(CycleCount), 11);

        mem_req_cycles = 0;
        run_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, 1);
        chk("store_req_cycles", 32'(mem_req_cycles), 1);
        chk("store_cnt", 32'(CycleCount), 16);

        run_instr(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'h2A, 1);
        chk("br_taken_pc", 32'(PC), 32'h2A);
        run_instr(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'h3FF, 1);
        chk("br_to_top_pc", 32'(PC), 32'h3FF);
        run_instr(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'h155, 1);
        chk("br_wrap_pc", 32'(PC), 0);
        chk("br_wrap_cnt", 32'(CycleCount), 28);

        run_instr(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd5, 1);
        run_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1);
        repeat (2) quiet_cycle();
        chk("halt_done", 32'(Done), 1);
        chk("halt_pc", 32'(PC), 5);
        chk("halt_cnt", 32'(CycleCount), 34);
        restart_cycle();
        chk("restart_pc", 32'(PC), 0);
        chk("restart_done", 32'(Done), 0);
        chk("restart_irload", 32'(IRLoad), 1);
        chk("restart_cnt", 32'(CycleCount), 0);

        repeat (70) rand_instr(1'b0);
        chk("sat_cnt", 32'(CycleCount), 32'(CNT_MAX));

        repeat (150) rand_instr(1'b1);

        Halt = 1'b0; Branch = 1'b0; MemRead = 1'b1; MemWrite = 1'b1;
        noise(); cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        noise(); cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        noise(); cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        MemAck = 1'b0;
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        Reset = 1'b1;
        #2;
        chk("midmem_rst_pc", 32'(PC), 0);
        chk("midmem_rst_flags", 32'({IRLoad, MemReq, MemWe, RegWrite, Done}), 0);
        chk("midmem_rst_cnt", 32'(CycleCount), 0);
        @(posedge Clk);
        #1 Reset = 1'b0;
        m_pc = '0; m_cnt = '0; m_done = 1'b0;
        Start = 1'b0; MemAck = 1'b1;
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        MemAck = 1'b0;
        chk("late_ack_flags", 32'({IRLoad, MemReq, MemWe, RegWrite, Done}), 0);
        chk("late_ack_cnt", 32'(CycleCount), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
